// File: rtl/multi_delta_reset.sv
// multi_delta_reset
//   Generates independent reset pulses for NCH channels. A rising edge on
//   delta_trig[i] launches a pulse of max(pulse_len,1) cycles on delta_rst[i],
//   optionally followed by HOLDOFF dead cycles. Edges that cannot start or
//   restart a pulse are tallied in a per-channel saturating miss counter.
// Ports
//   clk        : single clock
//   rst        : asynchronous active-low reset
//   delta_trig : per-channel trigger level (NCH)
//   pulse_len  : pulse length in cycles, sampled at each load (CNT_W)
//   retrig     : 1 = edge during a pulse restarts it, 0 = edge is missed
//   clr_miss   : synchronous clear of all miss counters (wins over a miss)
//   delta_rst  : per-channel reset pulse (registered)
//   any_rst    : registered OR of delta_rst, one cycle behind it
//   busy       : channel in PULSE or HOLD (registered alongside delta_rst)
//   miss_cnt   : channel i in bits [i*MISS_W +: MISS_W]
module multi_delta_reset #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 9,
  parameter int HOLDOFF = 0,
  parameter int MISS_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        delta_trig,
  input  logic [CNT_W-1:0]      pulse_len,
  input  logic                  retrig,
  input  logic                  clr_miss,
  output logic [NCH-1:0]        delta_rst,
  output logic                  any_rst,
  output logic [NCH-1:0]        busy,
  output logic [NCH*MISS_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLDOFF);
  localparam logic              HAS_HOLD  = (HOLDOFF > 0);
  localparam logic [MISS_W-1:0] MISS_ONE  = {{(MISS_W-1){1'b0}}, 1'b1};
  localparam logic [MISS_W-1:0] MISS_MAX  = {MISS_W{1'b1}};

  logic [NCH-1:0]    d1_q, d1_d, d2_q, d2_d;
  logic [NCH-1:0]    trig_edge;
  state_e            state_q [NCH];
  state_e            state_d [NCH];
  logic [CNT_W-1:0]  cnt_q   [NCH];
  logic [CNT_W-1:0]  cnt_d   [NCH];
  logic [MISS_W-1:0] miss_q  [NCH];
  logic [MISS_W-1:0] miss_d  [NCH];
  logic [NCH-1:0]    delta_rst_q, delta_rst_d;
  logic [NCH-1:0]    busy_q, busy_d;
  logic              any_rst_q, any_rst_d;
  logic [CNT_W-1:0]  load_len;

  // Zero-length request still yields a one-cycle pulse.
  assign load_len  = (pulse_len == {CNT_W{1'b0}}) ? CNT_ONE : pulse_len;
  assign trig_edge = d1_q & ~d2_q;

  // Per-channel next-state, counter, miss-counter and output decode.
  always_comb begin
    logic miss_inc;
    miss_inc    = 1'b0;
    d1_d        = delta_trig;
    d2_d        = d1_q;
    delta_rst_d = '0;
    busy_d      = '0;
    any_rst_d   = |delta_rst_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      miss_inc   = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          if (trig_edge[i]) begin
            state_d[i] = ST_PULSE;
            cnt_d[i]   = load_len;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_PULSE: begin
          if (trig_edge[i] && retrig) begin
            cnt_d[i] = load_len;
          end else begin
            miss_inc = trig_edge[i];
            // Counter never legitimately reaches 0 in PULSE; <= keeps it safe.
            if (cnt_q[i] <= CNT_ONE) begin
              if (HAS_HOLD) begin
                state_d[i] = ST_HOLD;
                cnt_d[i]   = HOLD_LOAD;
              end else begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
        end
        ST_HOLD: begin
          // An edge on the expiry cycle is still in HOLD, hence missed.
          miss_inc = trig_edge[i];
          if (cnt_q[i] <= CNT_ONE) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase

      if (clr_miss) begin
        miss_d[i] = '0;
      end else if (miss_inc && (miss_q[i] != MISS_MAX)) begin
        miss_d[i] = miss_q[i] + MISS_ONE;
      end else begin
        miss_d[i] = miss_q[i];
      end

      delta_rst_d[i] = (state_q[i] == ST_PULSE);
      busy_d[i]      = (state_q[i] != ST_IDLE);
    end
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Synchronizer preset high: a level held through reset is not an edge.
      d1_q        <= '1;
      d2_q        <= '1;
      delta_rst_q <= '0;
      busy_q      <= '0;
      any_rst_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        miss_q[i]  <= '0;
      end
    end else begin
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      delta_rst_q <= delta_rst_d;
      busy_q      <= busy_d;
      any_rst_q   <= any_rst_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        miss_q[i]  <= miss_d[i];
      end
    end
  end

  // Pack miss counters onto the flat output bus.
  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      miss_cnt[i*MISS_W +: MISS_W] = miss_q[i];
    end
  end

  assign delta_rst = delta_rst_q;
  assign busy      = busy_q;
  assign any_rst   = any_rst_q;

endmodule

// File: tb/tb_multi_delta_reset.sv
// Self-checking bench for multi_delta_reset: a HOLDOFF=0 instance (dut) and a
// HOLDOFF=4 instance (dut_h) share all inputs. Expected results are queued
// when stimulus is driven and popped when the DUT output is sampled.
module tb_multi_delta_reset;
  localparam int NCH = 4;
  localparam int CNT_W = 9;
  localparam int MISS_W = 8;

  typedef logic [2*NCH:0] obs_t;  // {busy, any_rst, delta_rst}

  logic                  clk;
  logic                  rst;
  logic [NCH-1:0]        delta_trig;
  logic [CNT_W-1:0]      pulse_len;
  logic                  retrig;
  logic                  clr_miss;
  logic [NCH-1:0]        delta_rst, delta_rst_h;
  logic                  any_rst, any_rst_h;
  logic [NCH-1:0]        busy, busy_h;
  logic [NCH*MISS_W-1:0] miss_cnt, miss_cnt_h;

  int   n_checks = 0;
  int   n_pass = 0;
  int   hi0 = 0;
  int   hih = 0;
  obs_t sb_q[$];
  int   len_q[$];
  int   miss_q[$];

  multi_delta_reset #(.NCH(NCH), .CNT_W(CNT_W), .HOLDOFF(0), .MISS_W(MISS_W)) dut (
    .clk(clk), .rst(rst), .delta_trig(delta_trig), .pulse_len(pulse_len),
    .retrig(retrig), .clr_miss(clr_miss), .delta_rst(delta_rst),
    .any_rst(any_rst), .busy(busy), .miss_cnt(miss_cnt)
  );

  multi_delta_reset #(.NCH(NCH), .CNT_W(CNT_W), .HOLDOFF(4), .MISS_W(MISS_W)) dut_h (
    .clk(clk), .rst(rst), .delta_trig(delta_trig), .pulse_len(pulse_len),
    .retrig(retrig), .clr_miss(clr_miss), .delta_rst(delta_rst_h),
    .any_rst(any_rst_h), .busy(busy_h), .miss_cnt(miss_cnt_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running count of cycles with channel-0 pulse high, per instance.
  always @(negedge clk) begin
    if (delta_rst[0]) hi0 <= hi0 + 1;
    if (delta_rst_h[0]) hih <= hih + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_miss();
    clr_miss = 1'b1;
    tick();
    clr_miss = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    delta_trig = '0;
    pulse_len = 9'd0;
    retrig = 1'b0;
    clr_miss = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({delta_rst, any_rst, busy, miss_cnt} !== {4'b0000, 1'b0, 4'b0000, 32'h0000_0000})
      $display("FAIL reset_hold: got %h expected all zero", {delta_rst, any_rst, busy, miss_cnt});
    else n_pass++;
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({delta_rst, any_rst, busy, miss_cnt} !== {4'b0000, 1'b0, 4'b0000, 32'h0000_0000})
      $display("FAIL reset_release: got %h expected all zero", {delta_rst, any_rst, busy, miss_cnt});
    else n_pass++;
  endtask

  // 100-cycle pulse on ch0; pulse_len changed mid-pulse must not matter.
  task automatic test_single_pulse();
    obs_t exp_o, act_o;
    logic dr, ar;
    pulse_len = 9'd100;
    retrig = 1'b0;
    delta_trig = 4'b0001;
    tick();                       // trigger sampled here (edge N)
    delta_trig = 4'b0000;
    for (int c = 1; c <= 104; c++) begin
      dr = (c >= 2) && (c <= 101);
      ar = (c >= 3) && (c <= 102);
      sb_q.push_back({(dr ? 4'b0001 : 4'b0000), ar, (dr ? 4'b0001 : 4'b0000)});
    end
    for (int c = 1; c <= 104; c++) begin
      tick();
      if (c == 3) pulse_len = 9'd7;
      act_o = {busy, any_rst, delta_rst};
      exp_o = sb_q.pop_front();
      n_checks++;
      if (act_o !== exp_o)
        $display("FAIL single_pulse cyc N+%0d: got %b expected %b", c, act_o, exp_o);
      else n_pass++;
    end
  endtask

  task automatic test_multi_channel();
    obs_t exp_o, act_o;
    logic dr, ar;
    pulse_len = 9'd5;
    delta_trig = 4'b1011;
    tick();
    delta_trig = 4'b0000;
    for (int c = 1; c <= 8; c++) begin
      dr = (c >= 2) && (c <= 6);
      ar = (c >= 3) && (c <= 7);
      sb_q.push_back({(dr ? 4'b1011 : 4'b0000), ar, (dr ? 4'b1011 : 4'b0000)});
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      act_o = {busy, any_rst, delta_rst};
      exp_o = sb_q.pop_front();
      n_checks++;
      if (act_o !== exp_o)
        $display("FAIL multi_channel cyc N+%0d: got %b expected %b", c, act_o, exp_o);
      else n_pass++;
    end
  endtask

  // Second edge 5 cycles into a 10-cycle pulse, with and without retrigger.
  task automatic test_retrig();
    int s, e;
    for (int r = 1; r >= 0; r--) begin
      clear_miss();
      pulse_len = 9'd10;
      retrig = (r == 1);
      len_q.push_back((r == 1) ? 15 : 10);
      miss_q.push_back((r == 1) ? 0 : 1);
      s = hi0;
      delta_trig = 4'b0001;
      tick();
      delta_trig = 4'b0000;
      repeat (4) tick();
      delta_trig = 4'b0001;
      tick();
      delta_trig = 4'b0000;
      repeat (30) tick();
      e = len_q.pop_front();
      n_checks++;
      if (hi0 - s !== e)
        $display("FAIL retrig%0d_len: got %0d expected %0d", r, hi0 - s, e);
      else n_pass++;
      e = miss_q.pop_front();
      n_checks++;
      if (int'(miss_cnt[7:0]) !== e)
        $display("FAIL retrig%0d_miss: got %0d expected %0d", r, miss_cnt[7:0], e);
      else n_pass++;
    end
    retrig = 1'b0;
  endtask

  // HOLDOFF=4, pulse_len=3: edges 1, 4, 5 cycles after the pulse ends.
  task automatic test_holdoff();
    int s, e;
    int ks[3] = '{1, 4, 5};
    for (int j = 0; j < 3; j++) begin
      clear_miss();
      pulse_len = 9'd3;
      retrig = 1'b0;
      len_q.push_back((ks[j] == 5) ? 6 : 3);
      miss_q.push_back((ks[j] == 5) ? 0 : 1);
      s = hih;
      delta_trig = 4'b0001;
      tick();
      delta_trig = 4'b0000;
      repeat (2 + ks[j]) tick();
      delta_trig = 4'b0001;
      tick();
      delta_trig = 4'b0000;
      repeat (25) tick();
      e = len_q.pop_front();
      n_checks++;
      if (hih - s !== e)
        $display("FAIL holdoff_k%0d_len: got %0d expected %0d", ks[j], hih - s, e);
      else n_pass++;
      e = miss_q.pop_front();
      n_checks++;
      if (int'(miss_cnt_h[7:0]) !== e)
        $display("FAIL holdoff_k%0d_miss: got %0d expected %0d", ks[j], miss_cnt_h[7:0], e);
      else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    int s;
    pulse_len = 9'd0;
    len_q.push_back(1);
    s = hi0;
    delta_trig = 4'b0001;
    tick();
    delta_trig = 4'b0000;
    repeat (10) tick();
    n_checks++;
    if (hi0 - s !== len_q[0])
      $display("FAIL zero_len: got %0d expected %0d", hi0 - s, len_q[0]);
    else n_pass++;
    void'(len_q.pop_front());
  endtask

  // 300 misses saturate at 255; clear (also coinciding with a miss) zeroes.
  task automatic test_saturate();
    int e;
    clear_miss();
    pulse_len = 9'd511;
    retrig = 1'b0;
    miss_q.push_back(250);
    miss_q.push_back(255);
    miss_q.push_back(0);
    miss_q.push_back(1);
    delta_trig = 4'b0001;
    tick();
    delta_trig = 4'b0000;
    tick();
    for (int j = 0; j < 250; j++) begin
      delta_trig = 4'b0001; tick();
      delta_trig = 4'b0000; tick();
    end
    e = miss_q.pop_front();
    n_checks++;
    if (int'(miss_cnt[7:0]) !== e)
      $display("FAIL miss_250: got %0d expected %0d", miss_cnt[7:0], e);
    else n_pass++;
    repeat (20) tick();
    delta_trig = 4'b0001;
    tick();
    delta_trig = 4'b0000;
    tick();
    for (int j = 0; j < 50; j++) begin
      delta_trig = 4'b0001; tick();
      delta_trig = 4'b0000; tick();
    end
    e = miss_q.pop_front();
    n_checks++;
    if (int'(miss_cnt[7:0]) !== e)
      $display("FAIL miss_sat: got %0d expected %0d", miss_cnt[7:0], e);
    else n_pass++;
    delta_trig = 4'b0001;
    tick();
    delta_trig = 4'b0000;
    clr_miss = 1'b1;
    tick();                       // miss and clear on the same edge
    clr_miss = 1'b0;
    e = miss_q.pop_front();
    n_checks++;
    if (int'(miss_cnt[7:0]) !== e)
      $display("FAIL miss_clr_wins: got %0d expected %0d", miss_cnt[7:0], e);
    else n_pass++;
    delta_trig = 4'b0001; tick();
    delta_trig = 4'b0000; tick();
    e = miss_q.pop_front();
    n_checks++;
    if (int'(miss_cnt[7:0]) !== e)
      $display("FAIL miss_after_clr: got %0d expected %0d", miss_cnt[7:0], e);
    else n_pass++;
    repeat (520) tick();
  endtask

  // Async reset mid-pulse with trigger held high through release.
  task automatic test_reset_mid_pulse();
    int s;
    pulse_len = 9'd20;
    delta_trig = 4'b0001;
    tick();
    repeat (5) tick();
    n_checks++;
    if (delta_rst[0] !== 1'b1)
      $display("FAIL mid_pulse_active: got %b expected 1", delta_rst[0]);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({delta_rst, any_rst, busy, miss_cnt_h} !== {4'b0000, 1'b0, 4'b0000, 32'h0000_0000})
      $display("FAIL async_reset: got %h expected all zero", {delta_rst, any_rst, busy, miss_cnt_h});
    else n_pass++;
    repeat (2) tick();
    rst = 1'b1;
    s = hi0;
    repeat (15) tick();
    n_checks++;
    if (hi0 - s !== 0)
      $display("FAIL held_trig_no_pulse: got %0d expected 0", hi0 - s);
    else n_pass++;
    delta_trig = 4'b0000;
    repeat (2) tick();
    delta_trig = 4'b0001;
    tick();
    delta_trig = 4'b0000;
    repeat (25) tick();
    n_checks++;
    if (hi0 - s !== 20)
      $display("FAIL retrigger_after_reset: got %0d expected 20", hi0 - s);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_multi_channel();
    test_retrig();
    test_holdoff();
    test_zero_len();
    test_saturate();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
